// File: rtl/cpu_instr_encoder_pkg.sv
// Shared definitions for the instruction encoder. The decoder uses the same
// instruction-type codes and field widths.
//   INSTR_TYPE_WIDTH / OPCODE_WIDTH / FUNCT_WIDTH : request field widths
//   CPU_INSTR_LENGTH / CPU_XLEN / CPU_GREGIDX_WIDTH : word, data and register index widths
//   instr_type_e : instruction format codes carried on in_type
//   stage_t      : one pipeline stage (valid, error flag, assembled word)
package cpu_instr_encoder_pkg;

    localparam int INSTR_TYPE_WIDTH  = 4;
    localparam int OPCODE_WIDTH      = 7;
    localparam int FUNCT_WIDTH       = 10;
    localparam int CPU_INSTR_LENGTH  = 32;
    localparam int CPU_XLEN          = 32;
    localparam int CPU_GREGIDX_WIDTH = 5;

    typedef enum logic [INSTR_TYPE_WIDTH-1:0] {
        INSTR_INVALID = 4'd0,
        INSTR_R       = 4'd1,
        INSTR_I       = 4'd2,
        INSTR_S       = 4'd3,
        INSTR_B       = 4'd4,
        INSTR_U       = 4'd5,
        INSTR_J       = 4'd6,
        INSTR_R4      = 4'd7
    } instr_type_e;

    typedef struct packed {
        logic                        valid;
        logic                        err;
        logic [CPU_INSTR_LENGTH-1:0] instr;
    } stage_t;

endpackage

// File: rtl/cpu_instr_encoder_if.sv
// Request/response bus of the instruction encoder.
//   request : in_valid/in_ready handshake with type, opcode, funct, rd, rs1,
//             rs2, rs3 and a 32-bit sign-extended immediate
//   response: out_valid/out_ready handshake with the packed word and error flag
//   master  : the sequencer side (drives requests, consumes words)
//   slave   : the encoder side
interface cpu_instr_encoder_if;
    import cpu_instr_encoder_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic [INSTR_TYPE_WIDTH-1:0]  in_type;
    logic [OPCODE_WIDTH-1:0]      in_opcode;
    logic [FUNCT_WIDTH-1:0]       in_funct;
    logic [CPU_GREGIDX_WIDTH-1:0] in_rd;
    logic [CPU_GREGIDX_WIDTH-1:0] in_rs1;
    logic [CPU_GREGIDX_WIDTH-1:0] in_rs2;
    logic [CPU_GREGIDX_WIDTH-1:0] in_rs3;
    logic [CPU_XLEN-1:0]          in_imm;
    logic                         out_valid;
    logic                         out_ready;
    logic [CPU_INSTR_LENGTH-1:0]  out_instr;
    logic                         out_err;

    modport master (
        output in_valid, in_type, in_opcode, in_funct, in_rd, in_rs1, in_rs2, in_rs3, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_funct, in_rd, in_rs1, in_rs2, in_rs3, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/cpu_instr_imm_pack.sv
// Combinational immediate packer: scatters the immediate into the bit
// positions its instruction format uses and flags values the format cannot
// represent (out of range, misaligned, or non-zero low bits for U).
//   instr_type : instruction format code
//   imm        : sign-extended byte-offset immediate
//   imm_field  : immediate bits in their instruction-word positions, 0 elsewhere
//   range_err  : immediate not encodable for this format
module cpu_instr_imm_pack
    import cpu_instr_encoder_pkg::*;
(
    input  logic [INSTR_TYPE_WIDTH-1:0] instr_type,
    input  logic [CPU_XLEN-1:0]         imm,
    output logic [CPU_INSTR_LENGTH-1:0] imm_field,
    output logic                        range_err
);

    always_comb begin
        // NOTE: both outputs get a default before the case so that no format
        // leaves them unassigned; a missing default here would infer a latch.
        imm_field = '0;
        range_err = 1'b0;
        case (instr_type)
            INSTR_I: begin
                imm_field[31:20] = imm[11:0];
                range_err        = imm != {{20{imm[11]}}, imm[11:0]};
            end
            INSTR_S: begin
                imm_field[31:25] = imm[11:5];
                imm_field[11:7]  = imm[4:0];
                range_err        = imm != {{20{imm[11]}}, imm[11:0]};
            end
            INSTR_B: begin
                imm_field[31]    = imm[12];
                imm_field[30:25] = imm[10:5];
                imm_field[11:8]  = imm[4:1];
                imm_field[7]     = imm[11];
                range_err        = imm[0] || (imm != {{19{imm[12]}}, imm[12:0]});
            end
            INSTR_U: begin
                imm_field[31:12] = imm[31:12];
                range_err        = |imm[11:0];
            end
            INSTR_J: begin
                imm_field[31]    = imm[20];
                imm_field[30:21] = imm[10:1];
                imm_field[20]    = imm[11];
                imm_field[19:12] = imm[19:12];
                range_err        = imm[0] || (imm != {{11{imm[20]}}, imm[20:0]});
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_instr_encoder.sv
// RV32I/M/F instruction encoder with a 2-stage valid/ready pipeline.
// S1 registers the assembled word and error flag, S2 is the output register.
//   clk, rst_n : core clock, asynchronous active-low reset
//   flush      : synchronous clear of both stage valids; blocks new requests
//   bus        : request/response bus (slave side)
//   err_cnt    : saturating count of errored words delivered
module cpu_instr_encoder
    import cpu_instr_encoder_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    cpu_instr_encoder_if.slave       bus,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    logic [CPU_INSTR_LENGTH-1:0] imm_field;
    logic                        range_err;
    logic [CPU_INSTR_LENGTH-1:0] word;
    logic                        word_err;
    logic                        type_err;
    logic use_rd, use_rs1, use_rs2, use_rs3, use_f3, use_f7, use_fmt;

    stage_t                      s1_q, s1_d, s2_q, s2_d;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic                        in_ready, in_fire, out_fire, s2_free;

    cpu_instr_imm_pack u_imm_pack (
        .instr_type (bus.in_type),
        .imm        (bus.in_imm),
        .imm_field  (imm_field),
        .range_err  (range_err)
    );

    // Word assembly: pick the register/funct fields each format carries and
    // merge them with the packed immediate. Unused fields stay zero.
    always_comb begin
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rs3  = 1'b0;
        use_f3   = 1'b0;
        use_f7   = 1'b0;
        use_fmt  = 1'b0;
        type_err = 1'b0;
        case (bus.in_type)
            INSTR_R:          begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1; end
            INSTR_I:          begin use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; end
            INSTR_S, INSTR_B: begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; end
            INSTR_U, INSTR_J: begin use_rd = 1'b1; end
            INSTR_R4:         begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rs3 = 1'b1;
                                    use_f3 = 1'b1; use_fmt = 1'b1; end
            default:          type_err = 1'b1;
        endcase

        word = imm_field | {{(CPU_INSTR_LENGTH-OPCODE_WIDTH){1'b0}}, bus.in_opcode};
        if (use_rd)  word[11:7]  = bus.in_rd;
        if (use_rs1) word[19:15] = bus.in_rs1;
        if (use_rs2) word[24:20] = bus.in_rs2;
        if (use_f3)  word[14:12] = bus.in_funct[2:0];
        if (use_f7)  word[31:25] = bus.in_funct[9:3];
        if (use_fmt) word[26:25] = bus.in_funct[4:3];
        if (use_rs3) word[31:27] = bus.in_rs3;

        word_err = type_err || range_err;
        if (word_err) word = '0;
    end

    // S2 can take a new word when it is empty or its word leaves this cycle;
    // S1 can take a request when it is empty or drains into S2.
    assign s2_free  = !s2_q.valid || bus.out_ready;
    assign out_fire = s2_q.valid && bus.out_ready;
    assign in_ready = !flush && (!s1_q.valid || s2_free);
    assign in_fire  = bus.in_valid && in_ready;

    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        err_cnt_d = err_cnt_q;

        if (s2_free) begin
            if (s1_q.valid) s2_d = s1_q;
            else            s2_d.valid = 1'b0;
            s1_d.valid = 1'b0;
        end
        if (in_fire) s1_d = '{valid: 1'b1, err: word_err, instr: word};

        // Flush drops in-flight words but keeps the counter; a transfer in the
        // flush cycle has already happened and is still counted below.
        if (flush) begin
            s1_d.valid = 1'b0;
            s2_d.valid = 1'b0;
        end

        if (out_fire && s2_q.err && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            err_cnt_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_q.valid;
    assign bus.out_instr = s2_q.instr;
    assign bus.out_err   = s2_q.err;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_cpu_instr_encoder.sv
// Self-checking bench for cpu_instr_encoder. A second instance with a 2-bit
// error counter sees the same stimulus to exercise counter saturation.
module tb_cpu_instr_encoder;
    import cpu_instr_encoder_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] err_cnt;
    logic [1:0]  sat_err_cnt;

    always #5 clk = ~clk;

    cpu_instr_encoder_if bus ();
    cpu_instr_encoder_if sat_bus ();

    assign sat_bus.in_valid  = bus.in_valid;
    assign sat_bus.in_type   = bus.in_type;
    assign sat_bus.in_opcode = bus.in_opcode;
    assign sat_bus.in_funct  = bus.in_funct;
    assign sat_bus.in_rd     = bus.in_rd;
    assign sat_bus.in_rs1    = bus.in_rs1;
    assign sat_bus.in_rs2    = bus.in_rs2;
    assign sat_bus.in_rs3    = bus.in_rs3;
    assign sat_bus.in_imm    = bus.in_imm;
    assign sat_bus.out_ready = bus.out_ready;

    cpu_instr_encoder #(.ERR_CNT_WIDTH(16)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    cpu_instr_encoder #(.ERR_CNT_WIDTH(2)) u_dut_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (sat_bus),
        .err_cnt (sat_err_cnt)
    );

    typedef struct {
        bit        err;
        bit [31:0] instr;
        int        acc_cyc;
    } exp_t;

    exp_t      exp_q[$];
    bit [31:0] got_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        n_err    = 0;
    int        cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] at(input bit [31:0] v, input int pos);
        return v << pos;
    endfunction

    // Reference encoder: range rules as signed-integer bounds, fields placed by
    // shifting masked values into position.
    function automatic exp_t ref_encode(input int t, input bit [6:0] op, input bit [9:0] f,
                                        input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                                        input bit [4:0] rs3, input bit [31:0] imm, input int acc_cyc);
        exp_t      e;
        int        si = $signed(imm);
        bit        ok = 1'b1;
        bit [31:0] w  = 32'(op);
        bit [31:0] f3 = at(32'(f) & 32'd7, 12);
        case (t)
            1: w |= at(rd, 7) | f3 | at(rs1, 15) | at(rs2, 20) | at(32'(f) >> 3, 25);
            2: begin
                ok = si >= -2048 && si <= 2047;
                w |= at(rd, 7) | f3 | at(rs1, 15) | at(imm & 32'hFFF, 20);
            end
            3: begin
                ok = si >= -2048 && si <= 2047;
                w |= at(imm & 32'h1F, 7) | f3 | at(rs1, 15) | at(rs2, 20) | at((imm >> 5) & 32'h7F, 25);
            end
            4: begin
                ok = (si % 2 == 0) && si >= -4096 && si <= 4095;
                w |= at((imm >> 11) & 1, 7) | at((imm >> 1) & 32'hF, 8) | f3 | at(rs1, 15) | at(rs2, 20)
                   | at((imm >> 5) & 32'h3F, 25) | at((imm >> 12) & 1, 31);
            end
            5: begin
                ok = (imm % 4096) == 0;
                w |= at(rd, 7) | (imm & 32'hFFFFF000);
            end
            6: begin
                ok = (si % 2 == 0) && si >= -(1 << 20) && si <= (1 << 20) - 1;
                w |= at(rd, 7) | at((imm >> 12) & 32'hFF, 12) | at((imm >> 11) & 1, 20)
                   | at((imm >> 1) & 32'h3FF, 21) | at((imm >> 20) & 1, 31);
            end
            7: w |= at(rd, 7) | f3 | at(rs1, 15) | at(rs2, 20) | at((32'(f) >> 3) & 32'd3, 25) | at(rs3, 27);
            default: ok = 1'b0;
        endcase
        e.err     = !ok;
        e.instr   = ok ? w : 32'h0;
        e.acc_cyc = acc_cyc;
        return e;
    endfunction

    function automatic bit [31:0] got_at(input int idx);
        return (idx < got_q.size()) ? got_q[idx] : 32'hBAD0BAD0;
    endfunction

    function automatic bit [31:0] rand_imm();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       return $urandom;
            2:       return $urandom & 32'hFFFFF000;
            3:       return (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFFFFFE;
            default: return (32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000) & 32'hFFFFFFFE;
        endcase
    endfunction

    // Cycle monitor: handshake expectations from model occupancy, in-order
    // scoreboard on every output transfer, error-counter tracking.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   exp_rdy;
        bit   exp_ov;
        if (rst_n) begin
            exp_rdy = !flush && (exp_q.size() < 2 || bus.out_ready);
            exp_ov  = 1'b0;
            if (exp_q.size() > 0) exp_ov = (cyc - exp_q[0].acc_cyc) >= 2;
            check("in_ready", bus.in_ready, exp_rdy);
            check("out_valid", bus.out_valid, exp_ov);
            check("err_cnt", err_cnt, 32'(n_err));
            check("sat_err_cnt", sat_err_cnt, 32'((n_err > 3) ? 3 : n_err));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", bus.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", bus.out_instr, e.instr);
                    check("out_err", bus.out_err, e.err);
                    if (e.err) n_err++;
                    got_q.push_back(bus.out_instr);
                end
            end
            if (flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_encode(int'(bus.in_type), bus.in_opcode, bus.in_funct, bus.in_rd,
                                           bus.in_rs1, bus.in_rs2, bus.in_rs3, bus.in_imm, cyc));
        end
    end

    // Presents one request and holds it until accepted; returns one step after
    // the accepting edge with in_valid still high.
    task automatic drive_req(input int t, input bit [6:0] op, input bit [9:0] f, input bit [4:0] rd,
                             input bit [4:0] rs1, input bit [4:0] rs2, input bit [31:0] imm,
                             output int acc_cyc);
        bit acc = 1'b0;
        acc_cyc       = -1;
        bus.in_valid  = 1'b1;
        bus.in_type   = 4'(t);
        bus.in_opcode = op;
        bus.in_funct  = f;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_rs3    = 5'd0;
        bus.in_imm    = imm;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc     = bus.in_ready;
            acc_cyc = cyc;
        end
        check("req_accepted", acc, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_c;
        int lat;
        bus.in_valid  = 1'b0;
        bus.in_type   = '0;
        bus.in_opcode = '0;
        bus.in_funct  = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_rs3    = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        #10 rst_n = 1'b1;
        #1 check("ready_after_reset", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // ADDI x1,x0,5 with latency measurement
        got_q.delete();
        drive_req(2, 7'h13, 10'd0, 5'd1, 5'd0, 5'd0, 32'd5, acc_c);
        bus.in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.out_valid) lat = cyc - acc_c;
        end
        check("addi_latency", lat, 2);
        wait_drain();
        check("addi_word", got_at(0), 32'h00500093);

        // LUI legal and with non-zero low bits
        got_q.delete();
        drive_req(5, 7'h37, 10'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, acc_c);
        drive_req(5, 7'h37, 10'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, acc_c);
        wait_drain();
        check("lui_word", got_at(0), 32'h123452B7);
        check("lui_bad_word", got_at(1), 32'h0);
        check("lui_err_cnt", err_cnt, 1);

        // BEQ x1,x2,-4 then JAL x1,8 back to back
        got_q.delete();
        drive_req(4, 7'h63, 10'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, acc_c);
        drive_req(6, 7'h6F, 10'd0, 5'd1, 5'd0, 5'd0, 32'd8, acc_c);
        wait_drain();
        check("beq_word", got_at(0), 32'hFE208EE3);
        check("jal_word", got_at(1), 32'h008000EF);

        // Backpressure: two accepts fill the pipe, outputs hold for 5 cycles
        got_q.delete();
        bus.out_ready = 1'b0;
        drive_req(1, 7'h33, 10'd0, 5'd3, 5'd1, 5'd2, 32'd0, acc_c);
        drive_req(2, 7'h13, 10'd0, 5'd1, 5'd0, 5'd0, 32'd5, acc_c);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_hold_instr", bus.out_instr, 32'h002081B3);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_drain();
        check("bp_first", got_at(0), 32'h002081B3);
        check("bp_second", got_at(1), 32'h00500093);

        // Error requests and counter saturation on the narrow instance
        got_q.delete();
        drive_req(2, 7'h13, 10'd0, 5'd1, 5'd1, 5'd0, 32'd2048, acc_c);
        drive_req(0, 7'h13, 10'd0, 5'd1, 5'd1, 5'd0, 32'd0, acc_c);
        wait_drain();
        check("imm2048_word", got_at(0), 32'h0);
        check("type0_word", got_at(1), 32'h0);
        check("err_cnt_three", err_cnt, 3);
        drive_req(9, 7'h13, 10'd0, 5'd1, 5'd1, 5'd0, 32'd0, acc_c);
        drive_req(4, 7'h63, 10'd0, 5'd0, 5'd1, 5'd2, 32'd3, acc_c);
        drive_req(6, 7'h6F, 10'd0, 5'd1, 5'd0, 5'd0, 32'h00200000, acc_c);
        wait_drain();
        check("err_cnt_six", err_cnt, 6);
        check("sat_err_cnt_max", sat_err_cnt, 3);

        // Flush with both stages full
        bus.out_ready = 1'b0;
        drive_req(2, 7'h13, 10'd0, 5'd1, 5'd0, 5'd0, 32'd5, acc_c);
        drive_req(2, 7'h13, 10'd0, 5'd1, 5'd0, 5'd0, 32'd4096, acc_c);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_err_cnt", err_cnt, 6);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;

        // Randomized traffic with random backpressure and occasional flush
        for (int i = 0; i < 2000; i++) begin
            bus.out_ready = $urandom_range(0, 9) < 7;
            flush         = $urandom_range(0, 49) == 0;
            bus.in_valid  = $urandom_range(0, 9) < 7;
            bus.in_type   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 7));
            bus.in_opcode = 7'($urandom);
            bus.in_funct  = 10'($urandom);
            bus.in_rd     = 5'($urandom);
            bus.in_rs1    = 5'($urandom);
            bus.in_rs2    = 5'($urandom);
            bus.in_rs3    = 5'($urandom);
            bus.in_imm    = rand_imm();
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of traffic
        flush        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_type  = 4'd2;
        bus.in_imm   = 32'd2048;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_instr", bus.out_instr, 0);
        check("arst_out_err", bus.out_err, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_sat_err_cnt", sat_err_cnt, 0);
        exp_q.delete();
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        drive_req(2, 7'h13, 10'd0, 5'd1, 5'd0, 5'd0, 32'd5, acc_c);
        wait_drain();
        check("post_reset_word", got_at(0), 32'h00500093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_instr_encoder.md
# cpu_instr_encoder

Pipelined RV32I/[M]/[F] instruction encoder: accepts an instruction type, opcode, funct, register indices and a 32-bit immediate, and emits the packed 32-bit instruction word. It is the inverse of the core's instruction decoder and sits between the self-test/boot sequencer and the instruction memory write port. It range-checks immediates and flags unencodable requests. Input and output use valid/ready handshakes, with a 2-stage registered pipeline at full throughput.

## Interface
Parameters:
- ERR_CNT_WIDTH, 16, width of the saturating error counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_type  in  4  instruction type: 0 invalid, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J, 7 R4
- in_opcode  in  7  instr[6:0]
- in_funct  in  10  R: {funct7,funct3}; I/S/B: funct3 in [2:0]; R4: {fmt,rm} in [4:0]
- in_rd, in_rs1, in_rs2, in_rs3  in  5 each  register indices
- in_imm  in  32  immediate, byte offset, sign-extended value
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_err  out  1  request was unencodable; out_instr is 0
- err_cnt  out  ERR_CNT_WIDTH  saturating count of errored requests delivered

## Operation
- Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
- Stage 1 (S1) registers the assembled word and the error flag. Stage 2 (S2) is the output register.
- Field placement:
  - rd → [11:7]; rs1 → [19:15]; rs2 → [24:20].
  - R: funct[9:3] → [31:25], funct[2:0] → [14:12].
  - I: imm[11:0] → [31:20].
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7].
  - B: imm[12] → [31], imm[10:5] → [30:25], imm[4:1] → [11:8], imm[11] → [7].
  - U: imm[31:12] → [31:12].
  - J: imm[20] → [31], imm[10:1] → [30:21], imm[11] → [20], imm[19:12] → [19:12].
  - R4: rs3 → [31:27], funct[4:3] → [26:25], funct[2:0] → [14:12].
- Fields a type does not use are zero in the word.
- Error conditions:
  - I/S: in_imm ≠ sext(in_imm[11:0]).
  - B: in_imm[0] = 1, or in_imm ≠ sext(in_imm[12:0]).
  - U: in_imm[11:0] ≠ 0.
  - J: in_imm[0] = 1, or in_imm ≠ sext(in_imm[20:0]).
  - in_type is 0 or greater than 7.
- On error: out_instr = 32'h0, out_err = 1.
- err_cnt increments on each output transfer with out_err = 1 and saturates at all-ones.
- flush:
  - Clears S1 and S2 valid bits on the next edge.
  - in_ready = 0 while flush is high, so no request is accepted in that cycle.
  - err_cnt is not cleared by flush.
  - If an output transfer coincides with flush, it completes and is counted.

## Timing
- Reset values: out_valid 0, out_instr 0, out_err 0, err_cnt 0, both stage valids 0.
- in_ready = !flush && (!S1.valid || !S2.valid || out_ready). After reset release it is 1 immediately.
- Latency: 2 cycles from input transfer to out_valid, with no backpressure.
- Throughput: one request per cycle while out_ready = 1.
- Backpressure:
  - When out_ready = 0, S2 holds and S1 fills. A third request stalls: in_ready = 0.
  - Both stages hold stable data until accepted.
- out_valid, out_instr and out_err are registered and never change while out_valid && !out_ready, except on flush or reset.
- Reset mid-operation: all state clears asynchronously; in-flight requests are lost.

## Structure
- Shared package/header `cpu_define.v` holds:
  - instruction-type codes and INSTR_TYPE_WIDTH (4);
  - FUNCT_WIDTH (10) and OPCODE_WIDTH (7);
  - CPU_INSTR_LENGTH, CPU_XLEN, CPU_GREGIDX_WIDTH.
- These codes are shared with the decoder; they are not redefined locally.
- One sub-module: `cpu_instr_imm_pack`, combinational, taking type and imm and returning the immediate bit-field pattern plus the range-error flag. The top module holds the handshake, the pipeline registers and err_cnt.

## Test plan
- ADDI x1,x0,5 (type 2, opcode 0x13, imm 5, rd 1) → out_instr 0x00500093, out_err 0, out_valid two cycles after accept.
- LUI x5,0x12345000 (type 5, opcode 0x37) → 0x123452B7. Same with imm 0x12345001 → out_err 1, instr 0, err_cnt 1.
- BEQ x1,x2,-4 (type 4, opcode 0x63, imm 0xFFFFFFFC) → 0xFE208EE3. JAL x1,8 (type 6, opcode 0x6F) → 0x008000EF.
- ADD x3,x1,x2 (type 1, opcode 0x33, funct 0) issued back-to-back with ADDI x1,x0,5, out_ready held low 5 cycles:
  - in_ready drops after the 2nd accept.
  - Outputs held stable, then delivered in order 0x002081B3, 0x00500093.
- I-type imm 2048 and in_type 0 → both out_err 1, err_cnt 2. With ERR_CNT_WIDTH = 2, five errors → err_cnt saturates at 3.
- Pipeline full (S1 and S2 valid), assert flush 1 cycle → out_valid 0 next cycle, in_ready 0 during flush, err_cnt unchanged. Async rst_n mid-stream → all outputs at reset values immediately.
